// File: rtl/sar_ctrl_pkg.sv
// Shared definitions for the SAR ADC controller: state encoding, synchronizer depth
// and the conversion latency helper.
package sar_ctrl_pkg;

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StSample = 2'd1,
      StTrial  = 2'd2,
      StDone   = 2'd3
   } sar_state_e;

   localparam int unsigned SYNC_STAGES = 2;

   // Edges from the start edge to the final decision edge; result_valid follows it.
   function automatic int unsigned conv_latency(input int unsigned sample_cycles,
                                                input int unsigned width,
                                                input int unsigned settle_cycles);
      return sample_cycles + width * (settle_cycles + SYNC_STAGES);
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit, reset to 0.
module sync_2ff (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_d,
   output logic o_q
);

   logic r_meta;
   logic r_sync;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/sar_adc_ctrl.sv
// Successive-approximation controller: sequences track/hold, drives the DAC trial code
// and resolves the synchronized comparator into a WIDTH-bit result.
module sar_adc_ctrl
   import sar_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH         = 8,
   parameter int unsigned SAMPLE_CYCLES = 4,
   parameter int unsigned SETTLE_CYCLES = 1
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic             i_abort,
   input  logic             i_comp,
   output logic             o_sample_en,
   output logic [WIDTH-1:0] o_dac_code,
   output logic             o_busy,
   output logic [WIDTH-1:0] o_result,
   output logic             o_result_valid
);

   localparam int unsigned T_CYCLES = SETTLE_CYCLES + SYNC_STAGES;
   localparam int unsigned CNT_MAX  = (SAMPLE_CYCLES > T_CYCLES) ? SAMPLE_CYCLES - 1
                                                                 : T_CYCLES - 1;
   localparam int unsigned CNT_W    = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;
   localparam int unsigned IDX_W    = $clog2(WIDTH);

   localparam logic [CNT_W-1:0] CNT_SAMPLE = CNT_W'(SAMPLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_BIT    = CNT_W'(T_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
   localparam logic [IDX_W-1:0] IDX_MSB    = IDX_W'(WIDTH - 1);
   localparam logic [IDX_W-1:0] IDX_ONE    = IDX_W'(1);
   localparam logic [WIDTH-1:0] TRIAL_INIT = {1'b1, {(WIDTH - 1){1'b0}}};

   sar_state_e       r_state, w_state_d;
   logic [CNT_W-1:0] r_cnt, w_cnt_d;
   logic [IDX_W-1:0] r_idx, w_idx_d;
   logic [WIDTH-1:0] r_trial, w_trial_d;
   logic [WIDTH-1:0] r_result, w_result_d;
   logic             r_busy, w_busy_d;
   logic             r_sample_en, w_sample_en_d;
   logic             r_valid, w_valid_d;
   logic [WIDTH-1:0] w_trial_dec;
   logic             w_comp_s;

   sync_2ff u_comp_sync (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_d   (i_comp),
      .o_q   (w_comp_s)
   );

   // Trial code after deciding bit r_idx and (if any remain) proposing the next bit.
   always_comb begin
      w_trial_dec = r_trial;
      w_trial_dec[r_idx] = w_comp_s;
      if (r_idx != '0) begin
         w_trial_dec[r_idx - IDX_ONE] = 1'b1;
      end
   end

   always_comb begin
      w_state_d     = r_state;
      w_cnt_d       = r_cnt;
      w_idx_d       = r_idx;
      w_trial_d     = r_trial;
      w_result_d    = r_result;
      w_busy_d      = r_busy;
      w_sample_en_d = r_sample_en;
      w_valid_d     = 1'b0;

      if (i_abort) begin
         w_state_d     = StIdle;
         w_cnt_d       = '0;
         w_idx_d       = '0;
         w_trial_d     = '0;
         w_busy_d      = 1'b0;
         w_sample_en_d = 1'b0;
      end else begin
         case (r_state)
            StIdle, StDone: begin
               if (i_start) begin
                  w_state_d     = StSample;
                  w_cnt_d       = CNT_SAMPLE;
                  w_busy_d      = 1'b1;
                  w_sample_en_d = 1'b1;
               end else begin
                  w_state_d = StIdle;
               end
            end
            StSample: begin
               if (r_cnt == '0) begin
                  w_state_d     = StTrial;
                  w_sample_en_d = 1'b0;
                  w_trial_d     = TRIAL_INIT;
                  w_idx_d       = IDX_MSB;
                  w_cnt_d       = CNT_BIT;
               end else begin
                  w_cnt_d = r_cnt - CNT_ONE;
               end
            end
            StTrial: begin
               if (r_cnt != '0) begin
                  w_cnt_d = r_cnt - CNT_ONE;
               end else if (r_idx != '0) begin
                  w_trial_d = w_trial_dec;
                  w_idx_d   = r_idx - IDX_ONE;
                  w_cnt_d   = CNT_BIT;
               end else begin
                  w_state_d  = StDone;
                  w_result_d = w_trial_dec;
                  w_valid_d  = 1'b1;
                  w_busy_d   = 1'b0;
                  w_trial_d  = '0;
               end
            end
            default: begin
               w_state_d     = StIdle;
               w_busy_d      = 1'b0;
               w_sample_en_d = 1'b0;
               w_trial_d     = '0;
            end
         endcase
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state     <= StIdle;
         r_cnt       <= '0;
         r_idx       <= '0;
         r_trial     <= '0;
         r_result    <= '0;
         r_busy      <= 1'b0;
         r_sample_en <= 1'b0;
         r_valid     <= 1'b0;
      end else begin
         r_state     <= w_state_d;
         r_cnt       <= w_cnt_d;
         r_idx       <= w_idx_d;
         r_trial     <= w_trial_d;
         r_result    <= w_result_d;
         r_busy      <= w_busy_d;
         r_sample_en <= w_sample_en_d;
         r_valid     <= w_valid_d;
      end
   end

   // The trial register is zero outside TRIAL, so it drives the DAC directly.
   assign o_dac_code     = r_trial;
   assign o_sample_en    = r_sample_en;
   assign o_busy         = r_busy;
   assign o_result       = r_result;
   assign o_result_valid = r_valid;

   a_valid_not_busy : assert property (@(posedge i_clk) disable iff (i_rst)
      r_valid |-> !r_busy);
   a_sample_busy : assert property (@(posedge i_clk) disable iff (i_rst)
      r_sample_en |-> r_busy);
   a_idle_dac_zero : assert property (@(posedge i_clk) disable iff (i_rst)
      !r_busy |-> (r_trial == '0));

endmodule

// File: doc/sar_adc_ctrl.md
# sar_adc_ctrl

Digital successive-approximation controller for the mixed-signal test chip's on-die SAR ADC. It sequences the analog track/hold switch, drives the capacitive-DAC trial code, and resolves the asynchronous comparator output into a WIDTH-bit result with a start/busy/valid handshake. It sits between the tile's `ui_in`/`uo_out` pin logic and the analog macro. Its reset is driven from the inverted tile `rst_n`.

## Interface
- `WIDTH`, 8: result and DAC code width in bits (≥2).
- `SAMPLE_CYCLES`, 4: cycles `sample_en` is held high (≥1).
- `SETTLE_CYCLES`, 1: DAC settling cycles per bit trial before the comparator is captured (≥1).
- `clk`  in  1  single system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request a conversion; sampled only in IDLE.
- `abort`  in  1  cancel any conversion; highest priority.
- `comp`  in  1  raw asynchronous comparator output; 1 means Vin ≥ Vdac.
- `sample_en`  out  1  track/hold switch control; 1 means tracking.
- `dac_code`  out  WIDTH  trial code to the capacitive DAC.
- `busy`  out  1  conversion in progress.
- `result`  out  WIDTH  last completed conversion; held until the next completion.
- `result_valid`  out  1  one-cycle pulse when `result` updates.

## Operation
- States: IDLE, SAMPLE, TRIAL, DONE.
- IDLE:
  - `busy`, `sample_en` and `dac_code` are all 0.
  - `start`=1 with `abort`=0 moves to SAMPLE.
- SAMPLE:
  - `busy`=1, `sample_en`=1, `dac_code`=0 for exactly SAMPLE_CYCLES cycles.
  - Then moves to TRIAL with bit index k=WIDTH-1 and trial register = 1<<(WIDTH-1).
- TRIAL:
  - `dac_code` = trial register; each bit occupies T = SETTLE_CYCLES+2 cycles.
  - `comp` passes through a 2-flop synchronizer.
  - On the last cycle of a bit, the synchronized value decides: 0 clears bit k, 1 keeps it.
  - If k>0, also set bit k-1 and decrement k.
  - If k=0, go to DONE.
- DONE (one cycle):
  - `result` ← final trial value, `result_valid`=1, `busy`=0, `dac_code`=0.
  - Next state is IDLE.
  - `start`=1 in this cycle is accepted as if in IDLE (back-to-back conversion).
- `abort`=1 in any state forces IDLE at the next edge:
  - no `result_valid`; `result` is unchanged.
  - abort has priority over `start` and over the DONE transition.
- `start` while `busy`=1 is ignored; no queuing.
- The trial code never exceeds 2^WIDTH-1; no arithmetic wrap is possible.
- Reset (asynchronous, any time, including mid-conversion):
  - state IDLE; all outputs 0, including `result`; synchronizer and counters cleared.
  - The first `start` after reset release behaves normally.

## Timing
- Edge 0 = the clock edge at which `start` is sampled high in IDLE.
- `busy` and `sample_en` go high after edge 0.
- `sample_en` falls after edge S = SAMPLE_CYCLES; `dac_code` = 1<<(WIDTH-1) from the same edge.
- Decision for bit k occurs at edge S + (WIDTH-k)·T.
- The comparator value used for a decision is the one present one cycle after `dac_code` changed (SETTLE_CYCLES=1); this gives SETTLE_CYCLES of analog settling.
- `result_valid` is high and `busy` low in the cycle after edge S + WIDTH·T.
- Defaults: S=4, T=3, so the DONE cycle follows edge 28.
- A new `start` sampled in the DONE cycle makes that edge the next edge 0 (zero dead cycles).
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Shared package `sar_ctrl_pkg` holds:
  - the state encoding (IDLE/SAMPLE/TRIAL/DONE);
  - `SYNC_STAGES`=2;
  - a function for conversion latency S + WIDTH·(SETTLE_CYCLES+SYNC_STAGES), reused by the tile top and the bench.
- One sub-module: `sync_2ff` (1-bit, async active-high reset to 0) for `comp`.
- Remaining logic: one FSM, one shared down-counter for sample/settle, one bit index, trial and result registers.

## Test plan
Comparator model: `comp` = (vin ≥ `dac_code`), combinational. Default parameters unless stated.
- vin=0xA5, `start` pulse: `result`=0xA5, `result_valid` a single cycle after edge 28; `sample_en` high exactly 4 cycles.
- Extremes: vin=0x00 gives 0x00; vin=0xFF gives 0xFF. Check the `dac_code` sequence for 0xFF: 0x80, 0xC0, 0xE0 … 0xFF, each held 3 cycles.
- After a 0xA5 result, vin=0x3C and `abort` at edge 10: `busy`=0 after edge 10, no `result_valid`, `result` stays 0xA5, `dac_code`=0.
- `start` asserted again at edges 5 and 20 during a conversion: ignored, latency unchanged. `start` held high through DONE: second conversion begins with no idle cycle and returns the correct value.
- Reset asserted asynchronously mid-TRIAL (between edges): all outputs 0 immediately. A conversion after release of vin=0x5A gives 0x5A.
- WIDTH=4, SAMPLE_CYCLES=2, SETTLE_CYCLES=3: vin=0x9 gives 0x9 in the cycle after edge 2+4·5=22.
